pong_score_keeper: RTL and testbench
====================================

// Module: pong_score_keeper
// PURPOSE
//   Two-sided, parametrised scorer for the pong datapath, clocked on the pixel clock.
//   Each side earns a point when its paddle returns the ball. Points are committed at
//   the frame-start pixel, so displayed scores never change mid-frame.
//   Adds over the single-side scorer: a second side, a win limit with game-over
//   detection, BCD outputs for the score renderer, and one-cycle point strobes.
// PARAMETERS
//   SCORE_W    8   width of each binary score register
//   WIN_SCORE  15  score that ends the game; must be in 1..2**SCORE_W-1
//   BCD_DIGITS 3   BCD digits per side; must satisfy 10**BCD_DIGITS > WIN_SCORE
//   COMMIT_X   0   x_pixel value at which pending points commit
//   COMMIT_Y   0   y_pixel value at which pending points commit
// PORTS
//   clk_25MHz            in   1           pixel clock; the only clock
//   reset                in   1           synchronous, active-high
//   game_start           in   1           synchronous clear of all state; lower priority than reset
//   x_pixel              in   10          current scan x
//   y_pixel              in   10          current scan y
//   collision_left       in   1           ball touches left paddle
//   collision_right      in   1           ball touches right paddle
//   is_ball_moving_right in   1           current ball direction
//   score_left           out  SCORE_W     left binary score
//   score_right          out  SCORE_W     right binary score
//   bcd_left             out  4*BCD_DIGITS left score in BCD, digit 0 in LSBs
//   bcd_right            out  4*BCD_DIGITS right score in BCD, digit 0 in LSBs
//   point_left           out  1           1-cycle strobe on the left score increment
//   point_right          out  1           1-cycle strobe on the right score increment
//   game_over            out  1           sticky once any score reaches WIN_SCORE
//   winner               out  2           00 none, 01 left, 10 right, 11 tie
// BEHAVIOUR
//   Reset / clear
//   - reset or game_start at a clk_25MHz edge sets every output to 0.
//   - The same edge returns both side FSMs to IDLE. reset takes priority.
//   Side FSMs (identical, independent)
//   - Exit condition: left = is_ball_moving_right; right = !is_ball_moving_right.
//   - Commit condition: x_pixel==COMMIT_X && y_pixel==COMMIT_Y.
//   - IDLE -> ARMED when the side's collision is high and its exit condition is true.
//   - ARMED -> STAY on the commit condition.
//     - If game_over==0 at that edge: score+1, BCD+1 with decimal carry,
//       and the point strobe is high for exactly the next cycle.
//     - If game_over==1: no increment and no strobe.
//   - STAY -> IDLE when the exit condition becomes false (ball reversed).
//   - Collisions seen in ARMED or STAY are ignored: at most one point per return.
//   Timing
//   - Latency: score, BCD and strobe update on the edge that samples the commit pixel
//     while the side is ARMED.
//   - Arming and committing in the same cycle is not possible. A commit pixel in the
//     arming cycle is missed; the point commits at the next frame start.
//   Arithmetic
//   - Binary and BCD counters increment together, with no divider.
//   - Scores saturate at WIN_SCORE, because the game-over gate blocks further commits.
//   Game over
//   - game_over and winner are set on the same edge the first score reaches WIN_SCORE.
//   - If both sides commit on the same edge, both increment and both strobes fire.
//     If both then reach WIN_SCORE, winner = 11.
//   - game_over holds until reset or game_start. FSMs keep tracking the ball, but no
//     score changes while game_over is set.
//   Mid-operation clears
//   - game_start while ARMED discards the pending point: the FSM goes to IDLE with
//     no strobe.
// TESTING
//   1. Left collision with moving_right=1, then commit pixel -> score_left=1, bcd_left=12'h001, one point_left pulse.
//   2. Collision held high for 50 cycles in ARMED/STAY across 3 frames -> only +1; a second point only after direction reverses and returns.
//   3. Score 9 -> 10 -> bcd=12'h010. Drive left to WIN_SCORE=15 -> game_over=1, winner=01; a further hit -> score stays 15, no strobe.
//   4. Both sides ARMED at 14, same commit edge -> both 15, both strobes, winner=11.
//   5. game_start while left is ARMED -> scores 0, FSM IDLE; the next commit pixel gives no point.
//   6. reset held over a commit pixel -> all outputs 0; reset asserted on the same edge as game_start -> identical result.

Source files
------------

// File: rtl/pong_score_keeper.sv
`default_nettype none
// ============================================================================
// Module      : pong_score_keeper
// Description : Two-sided pong scorer. Points are committed at the frame-start
//               pixel, with BCD outputs, point strobes and game-over detection.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_score_keeper #(
    parameter int SCORE_W    = 8,
    parameter int WIN_SCORE  = 15,
    parameter int BCD_DIGITS = 3,
    parameter int COMMIT_X   = 0,
    parameter int COMMIT_Y   = 0
) (
    input  logic                    clk_25MHz,
    input  logic                    reset,
    input  logic                    game_start,
    input  logic [9:0]              x_pixel,
    input  logic [9:0]              y_pixel,
    input  logic                    collision_left,
    input  logic                    collision_right,
    input  logic                    is_ball_moving_right,
    output logic [SCORE_W-1:0]      score_left,
    output logic [SCORE_W-1:0]      score_right,
    output logic [4*BCD_DIGITS-1:0] bcd_left,
    output logic [4*BCD_DIGITS-1:0] bcd_right,
    output logic                    point_left,
    output logic                    point_right,
    output logic                    game_over,
    output logic [1:0]              winner
);

    localparam int                 c_BCD_W     = 4 * BCD_DIGITS;
    localparam logic [9:0]         c_COMMIT_X  = 10'(COMMIT_X);
    localparam logic [9:0]         c_COMMIT_Y  = 10'(COMMIT_Y);
    localparam logic [SCORE_W-1:0] c_WIN_SCORE = SCORE_W'(WIN_SCORE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_STAY  = 2'd2
    } side_state_t;

    logic               w_clear;
    logic               w_commit;
    logic               r_game_over;
    logic [1:0]         r_winner;
    logic [SCORE_W-1:0] w_score_q [2];
    logic [SCORE_W-1:0] w_score_d [2];
    logic [c_BCD_W-1:0] w_bcd_q   [2];
    logic [1:0]         w_point_q;
    logic               w_win_left;
    logic               w_win_right;

    assign w_clear  = reset | game_start;
    assign w_commit = (x_pixel == c_COMMIT_X) && (y_pixel == c_COMMIT_Y);

    // Side 0 scores on returns travelling right, side 1 on returns travelling left.
    for (genvar i = 0; i < 2; i++) begin : g_side
        side_state_t        r_state;
        side_state_t        w_state_next;
        logic               w_exit;
        logic               w_hit;
        logic [SCORE_W-1:0] r_score;
        logic [SCORE_W-1:0] w_score_next;
        logic [c_BCD_W-1:0] r_bcd;
        logic [c_BCD_W-1:0] w_bcd_inc;
        logic [c_BCD_W-1:0] w_bcd_next;
        logic [BCD_DIGITS-1:0] w_carry;
        logic               r_point;
        logic               w_point_next;

        assign w_exit = (i == 0) ? is_ball_moving_right : !is_ball_moving_right;
        assign w_hit  = (i == 0) ? collision_left : collision_right;

        assign w_carry[0] = 1'b1;
        for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_digit
            logic w_is_nine;
            assign w_is_nine = (r_bcd[4*d +: 4] == 4'd9);
            assign w_bcd_inc[4*d +: 4] = !w_carry[d] ? r_bcd[4*d +: 4] :
                                         w_is_nine   ? 4'd0 : r_bcd[4*d +: 4] + 4'd1;
            if (d < BCD_DIGITS - 1) begin : g_carry
                assign w_carry[d+1] = w_carry[d] & w_is_nine;
            end
        end

        always_ff @(posedge clk_25MHz) begin
            if (w_clear) begin
                r_state <= S_IDLE;
                r_score <= '0;
                r_bcd   <= '0;
                r_point <= 1'b0;
            end else begin
                r_state <= w_state_next;
                r_score <= w_score_next;
                r_bcd   <= w_bcd_next;
                r_point <= w_point_next;
            end
        end

        always_comb begin
            w_state_next = r_state;
            w_score_next = r_score;
            w_bcd_next   = r_bcd;
            w_point_next = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_hit && w_exit) begin
                        w_state_next = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (w_commit) begin
                        w_state_next = S_STAY;
                        // Once the game is decided the return is consumed silently.
                        if (!r_game_over) begin
                            w_score_next = r_score + SCORE_W'(1);
                            w_bcd_next   = w_bcd_inc;
                            w_point_next = 1'b1;
                        end
                    end
                end
                S_STAY: begin
                    if (!w_exit) begin
                        w_state_next = S_IDLE;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end

        assign w_score_q[i] = r_score;
        assign w_score_d[i] = w_score_next;
        assign w_bcd_q[i]   = r_bcd;
        assign w_point_q[i] = r_point;
    end

    // Look at next-state scores so the verdict lands on the winning commit edge.
    assign w_win_left  = (w_score_d[0] == c_WIN_SCORE);
    assign w_win_right = (w_score_d[1] == c_WIN_SCORE);

    always_ff @(posedge clk_25MHz) begin
        if (w_clear) begin
            r_game_over <= 1'b0;
            r_winner    <= 2'b00;
        end else if (!r_game_over && (w_win_left || w_win_right)) begin
            r_game_over <= 1'b1;
            r_winner    <= {w_win_right, w_win_left};
        end
    end

    assign score_left  = w_score_q[0];
    assign score_right = w_score_q[1];
    assign bcd_left    = w_bcd_q[0];
    assign bcd_right   = w_bcd_q[1];
    assign point_left  = w_point_q[0];
    assign point_right = w_point_q[1];
    assign game_over   = r_game_over;
    assign winner      = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_pong_score_keeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_score_keeper
// Description : Scoreboard bench for pong_score_keeper with a rule-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_score_keeper;

    localparam int c_WIN = 15;

    logic        clk_25MHz;
    logic        reset;
    logic        game_start;
    logic [9:0]  x_pixel;
    logic [9:0]  y_pixel;
    logic        collision_left;
    logic        collision_right;
    logic        is_ball_moving_right;
    logic [7:0]  score_left;
    logic [7:0]  score_right;
    logic [11:0] bcd_left;
    logic [11:0] bcd_right;
    logic        point_left;
    logic        point_right;
    logic        game_over;
    logic [1:0]  winner;

    pong_score_keeper dut (
        .clk_25MHz            (clk_25MHz),
        .reset                (reset),
        .game_start           (game_start),
        .x_pixel              (x_pixel),
        .y_pixel              (y_pixel),
        .collision_left       (collision_left),
        .collision_right      (collision_right),
        .is_ball_moving_right (is_ball_moving_right),
        .score_left           (score_left),
        .score_right          (score_right),
        .bcd_left             (bcd_left),
        .bcd_right            (bcd_right),
        .point_left           (point_left),
        .point_right          (point_right),
        .game_over            (game_over),
        .winner               (winner)
    );

    initial begin
        clk_25MHz = 1'b0;
        forever #20 clk_25MHz = ~clk_25MHz;
    end

    // Expected output word: {sl, sr, bl, br, pl, pr, go, winner}
    logic [44:0] exp_q [$];
    int n_checks = 0;
    int n_errors = 0;
    int n_cycle  = 0;

    // Rule-level model: per side, a pending point and a wait-for-reversal flag.
    int       m_score  [2];
    bit       m_pending[2];
    bit       m_wait   [2];
    bit       m_point  [2];
    bit       m_go;
    bit [1:0] m_win;

    function automatic logic [11:0] to_bcd(input int v);
        return 12'((v % 10) + ((v / 10) % 10) * 16 + ((v / 100) % 10) * 256);
    endfunction

    task automatic model_step(input bit r, input bit gs, input logic [9:0] x,
                              input logic [9:0] y, input bit cl, input bit cr, input bit dir);
        bit commit;
        bit hit [2];
        bit away[2];
        commit  = (x == 10'd0) && (y == 10'd0);
        hit[0]  = cl;
        hit[1]  = cr;
        away[0] = dir;
        away[1] = !dir;
        if (r || gs) begin
            for (int s = 0; s < 2; s++) begin
                m_score[s] = 0; m_pending[s] = 0; m_wait[s] = 0; m_point[s] = 0;
            end
            m_go  = 0;
            m_win = 2'b00;
            return;
        end
        for (int s = 0; s < 2; s++) begin
            m_point[s] = 0;
            if (m_pending[s]) begin
                if (commit) begin
                    m_pending[s] = 0;
                    m_wait[s]    = 1;
                    if (!m_go) begin
                        m_score[s] = m_score[s] + 1;
                        m_point[s] = 1;
                    end
                end
            end else if (m_wait[s]) begin
                if (!away[s]) m_wait[s] = 0;
            end else if (hit[s] && away[s]) begin
                m_pending[s] = 1;
            end
        end
        if (!m_go && (m_score[0] == c_WIN || m_score[1] == c_WIN)) begin
            m_go  = 1;
            m_win = {m_score[1] == c_WIN, m_score[0] == c_WIN};
        end
    endtask

    task automatic drive(input bit r, input bit gs, input logic [9:0] x, input logic [9:0] y,
                         input bit cl, input bit cr, input bit dir);
        @(negedge clk_25MHz);
        reset                = r;
        game_start           = gs;
        x_pixel              = x;
        y_pixel              = y;
        collision_left       = cl;
        collision_right      = cr;
        is_ball_moving_right = dir;
        model_step(r, gs, x, y, cl, cr, dir);
        exp_q.push_back({8'(m_score[0]), 8'(m_score[1]), to_bcd(m_score[0]), to_bcd(m_score[1]),
                         m_point[0], m_point[1], m_go, m_win});
    endtask

    task automatic idle(input int n, input bit dir);
        repeat (n) drive(1'b0, 1'b0, 10'd5, 10'd7, 1'b0, 1'b0, dir);
    endtask

    task automatic commit_px(input bit dir);
        drive(1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, dir);
    endtask

    task automatic left_point();
        idle(1, 1'b0);
        drive(1'b0, 1'b0, 10'd5, 10'd7, 1'b1, 1'b0, 1'b1);
        idle(1, 1'b1);
        commit_px(1'b1);
        idle(1, 1'b1);
    endtask

    task automatic right_point();
        idle(1, 1'b1);
        drive(1'b0, 1'b0, 10'd5, 10'd7, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b0);
        commit_px(1'b0);
        idle(1, 1'b0);
    endtask

    // Monitor: the DUT presents a full output word every cycle.
    initial begin
        logic [44:0] exp_w;
        logic [44:0] act_w;
        forever begin
            @(posedge clk_25MHz);
            #1;
            n_cycle++;
            if (exp_q.size() > 0) begin
                exp_w = exp_q.pop_front();
                act_w = {score_left, score_right, bcd_left, bcd_right,
                         point_left, point_right, game_over, winner};
                n_checks++;
                if (act_w !== exp_w) begin
                    n_errors++;
                    $display("FAIL outputs cycle %0d: got sl=%0d sr=%0d bl=%h br=%h pl=%b pr=%b go=%b win=%b, expected sl=%0d sr=%0d bl=%h br=%h pl=%b pr=%b go=%b win=%b",
                             n_cycle, act_w[44:37], act_w[36:29], act_w[28:17], act_w[16:5],
                             act_w[4], act_w[3], act_w[2], act_w[1:0],
                             exp_w[44:37], exp_w[36:29], exp_w[28:17], exp_w[16:5],
                             exp_w[4], exp_w[3], exp_w[2], exp_w[1:0]);
                end
            end
        end
    end

    initial begin
        bit       dir;
        bit       r, gs, cl, cr;
        int       sel;
        logic [9:0] x, y;

        reset = 1'b1; game_start = 1'b0; x_pixel = 10'd5; y_pixel = 10'd7;
        collision_left = 1'b0; collision_right = 1'b0; is_ball_moving_right = 1'b1;

        // Reset state, then a single left point.
        repeat (2) drive(1'b1, 1'b0, 10'd5, 10'd7, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 10'd5, 10'd7, 1'b1, 1'b0, 1'b1);
        idle(3, 1'b1);
        commit_px(1'b1);
        idle(3, 1'b1);

        // Collision held through several frames scores at most once per return.
        idle(1, 1'b0);
        for (int i = 0; i < 50; i++) begin
            if (i % 16 == 5) drive(1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 1'b1);
            else             drive(1'b0, 1'b0, 10'd9, 10'd0, 1'b1, 1'b0, 1'b1);
        end
        left_point();

        // Arm and commit pixel in the same cycle: point lands next frame.
        idle(1, 1'b0);
        drive(1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 1'b1);
        idle(2, 1'b1);
        commit_px(1'b1);

        // Drive left through 9->10 to the win limit and beyond.
        for (int i = 0; i < 15; i++) left_point();

        // Both sides at 14 commit on one edge.
        drive(1'b0, 1'b1, 10'd5, 10'd7, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) begin
            left_point();
            right_point();
        end
        idle(1, 1'b0);
        drive(1'b0, 1'b0, 10'd5, 10'd7, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 10'd5, 10'd7, 1'b0, 1'b1, 1'b0);
        commit_px(1'b0);
        idle(3, 1'b0);

        // game_start while armed discards the pending point.
        drive(1'b0, 1'b1, 10'd5, 10'd7, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 10'd5, 10'd7, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 10'd5, 10'd7, 1'b0, 1'b0, 1'b1);
        commit_px(1'b1);
        idle(2, 1'b1);

        // reset over a commit pixel, and reset together with game_start.
        idle(1, 1'b0);
        drive(1'b0, 1'b0, 10'd5, 10'd7, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
        commit_px(1'b1);
        drive(1'b0, 1'b0, 10'd5, 10'd7, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
        commit_px(1'b1);
        idle(2, 1'b1);

        // Randomized play.
        dir = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) dir = !dir;
            r   = ($urandom_range(0, 399) == 0);
            gs  = ($urandom_range(0, 149) == 0);
            cl  = ($urandom_range(0, 3) == 0);
            cr  = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 7);
            case (sel)
                0: begin x = 10'd0;                       y = 10'd0; end
                1: begin x = 10'd0;                       y = 10'($urandom_range(1, 1023)); end
                2: begin x = 10'($urandom_range(1, 1023)); y = 10'd0; end
                default: begin
                    x = 10'($urandom_range(0, 1023));
                    y = 10'($urandom_range(0, 1023));
                end
            endcase
            drive(r, gs, x, y, cl, cr, dir);
        end

        repeat (3) @(negedge clk_25MHz);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
